// File: rtl/id_alloc_queue.sv
// rtl/id_alloc_queue.sv - in-order ID allocator with program-order release, rollback and flush
// Head/tail/count ring of DEPTH IDs; ID fields carry a valid bit in the MSB.
module id_alloc_queue #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 32,
  parameter int ALLOC = 2,
  parameter int FREE  = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ALLOC-1:0]             alloc_req,
  output logic                         alloc_ready,
  output logic [ALLOC*(WIDTH+1)-1:0]   alloc_id,
  input  logic [FREE-1:0]              free_en,
  input  logic                         rb_valid,
  input  logic [WIDTH-1:0]             rb_id,
  input  logic                         rb_incl,
  input  logic                         flush,
  output logic [WIDTH:0]               head_id,
  output logic [CW-1:0]                count,
  output logic                         empty,
  output logic                         full,
  output logic                         err
);

  // Wide enough for any pointer plus DEPTH or a lane count, so no sum overflows.
  localparam int SW = WIDTH + 5;

  logic [WIDTH-1:0] head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic             err_q;

  logic [WIDTH-1:0] head_n, tail_n;
  logic [SW-1:0]    count_n;
  logic             err_n;

  logic [SW-1:0]    n_req, n_free, f_eff, cnt_ext, cnt_rel;
  logic [SW-1:0]    rb_ext, rb_d, rb_keep;
  logic [WIDTH-1:0] head_rel, rb_tail;
  logic             free_err, rb_bad;

  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + b;
    return WIDTH'(s % SW'(DEPTH));
  endfunction

  always_comb begin
    n_req  = '0;
    n_free = '0;
    for (int i = 0; i < ALLOC; i++) n_req  = n_req  + SW'(alloc_req[i]);
    for (int i = 0; i < FREE;  i++) n_free = n_free + SW'(free_en[i]);
  end

  assign cnt_ext     = SW'(count_q);
  assign alloc_ready = !rst && !rb_valid && !flush && (n_req <= SW'(DEPTH) - cnt_ext);

  always_comb begin
    logic [SW-1:0] pre;
    alloc_id = '0;
    pre      = '0;
    for (int i = 0; i < ALLOC; i++) begin
      alloc_id[i*(WIDTH+1) +: WIDTH+1] = {alloc_req[i] & alloc_ready, wrap_add(tail_q, pre)};
      pre = pre + SW'(alloc_req[i]);
    end
  end

  // Releases are clamped to the live count seen before any same-cycle allocation.
  assign free_err = n_free > cnt_ext;
  assign f_eff    = free_err ? cnt_ext : n_free;
  assign head_rel = wrap_add(head_q, f_eff);
  assign cnt_rel  = cnt_ext - f_eff;

  assign rb_ext  = SW'(rb_id);
  assign rb_d    = (rb_ext >= SW'(head_q)) ? rb_ext - SW'(head_q)
                                           : rb_ext + SW'(DEPTH) - SW'(head_q);
  assign rb_bad  = (rb_ext >= SW'(DEPTH)) || (rb_d >= cnt_ext);
  assign rb_keep = rb_d + SW'(!rb_incl);
  assign rb_tail = wrap_add(rb_id, SW'(!rb_incl));

  always_comb begin
    head_n  = head_rel;
    tail_n  = tail_q;
    count_n = cnt_rel;
    err_n   = err_q | free_err;
    if (flush) begin
      tail_n  = head_rel;
      count_n = '0;
    end else if (rb_valid) begin
      if (rb_bad) begin
        err_n = 1'b1;
      end else if (f_eff > rb_keep) begin
        // Releases reached past the rollback point: the queue simply drains.
        head_n  = rb_tail;
        tail_n  = rb_tail;
        count_n = '0;
      end else begin
        tail_n  = rb_tail;
        count_n = rb_keep - f_eff;
      end
    end else if (alloc_ready) begin
      tail_n  = wrap_add(tail_q, n_req);
      count_n = cnt_rel + n_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_n;
      tail_q  <= tail_n;
      count_q <= CW'(count_n);
      err_q   <= err_n;
    end
  end

  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign head_id = {!empty, head_q};
  assign err     = err_q;

endmodule

// File: tb/tb_id_alloc_queue.sv
// tb/tb_id_alloc_queue.sv - directed self-checking bench for id_alloc_queue
// Drives a DEPTH=6 instance (s_) and a DEPTH=32 instance (l_) side by side.
module tb_id_alloc_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic       s_rst, s_ready, s_rbv, s_incl, s_flush, s_empty, s_full, s_err;
  logic [1:0] s_req, s_free;
  logic [15:0] s_id;
  logic [6:0] s_rbid;
  logic [7:0] s_head;
  logic [2:0] s_count;

  logic       l_rst, l_ready, l_rbv, l_incl, l_flush, l_empty, l_full, l_err;
  logic [1:0] l_req, l_free;
  logic [15:0] l_id;
  logic [6:0] l_rbid;
  logic [7:0] l_head;
  logic [5:0] l_count;

  id_alloc_queue #(.WIDTH(7), .DEPTH(6), .ALLOC(2), .FREE(2)) u_small (
    .clk(clk), .rst(s_rst), .alloc_req(s_req), .alloc_ready(s_ready), .alloc_id(s_id),
    .free_en(s_free), .rb_valid(s_rbv), .rb_id(s_rbid), .rb_incl(s_incl), .flush(s_flush),
    .head_id(s_head), .count(s_count), .empty(s_empty), .full(s_full), .err(s_err)
  );

  id_alloc_queue #(.WIDTH(7), .DEPTH(32), .ALLOC(2), .FREE(2)) u_large (
    .clk(clk), .rst(l_rst), .alloc_req(l_req), .alloc_ready(l_ready), .alloc_id(l_id),
    .free_en(l_free), .rb_valid(l_rbv), .rb_id(l_rbid), .rb_incl(l_incl), .flush(l_flush),
    .head_id(l_head), .count(l_count), .empty(l_empty), .full(l_full), .err(l_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Live IDs 2..7 on the large instance, starting from reset state.
  task automatic build_2_7();
    l_req = 2'b11;
    repeat (4) tick();
    l_req  = 2'b00;
    l_free = 2'b11;
    tick();
    l_free = 2'b00;
  endtask

  task automatic test_reset();
    s_rst = 1'b1; l_rst = 1'b1; s_req = 2'b11; l_req = 2'b11;
    tick(); tick();
    checks++; if (s_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", s_count); end
    checks++; if (s_empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", s_empty); end
    checks++; if (s_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", s_full); end
    checks++; if (s_head !== 8'h00) begin fails++; $display("FAIL reset_head: got %h expected 00", s_head); end
    checks++; if (s_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", s_err); end
    checks++; if (s_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", s_ready); end
    checks++; if ({s_id[15], s_id[7]} !== 2'b00) begin fails++; $display("FAIL reset_id_msb: got %b expected 00", {s_id[15], s_id[7]}); end
    checks++; if (l_ready !== 1'b0) begin fails++; $display("FAIL reset_l_ready: got %b expected 0", l_ready); end
    s_rst = 1'b0; l_rst = 1'b0; s_req = 2'b00; l_req = 2'b00;
    tick();
  endtask

  task automatic test_fill();
    logic [7:0] e0, e1;
    for (int c = 0; c < 3; c++) begin
      e0 = 8'h80 + 8'(2 * c);
      e1 = 8'h81 + 8'(2 * c);
      s_req = 2'b11;
      #1;
      checks++; if (s_ready !== 1'b1) begin fails++; $display("FAIL fill_ready%0d: got %b expected 1", c, s_ready); end
      checks++; if (s_id[7:0] !== e0) begin fails++; $display("FAIL fill_id0_%0d: got %h expected %h", c, s_id[7:0], e0); end
      checks++; if (s_id[15:8] !== e1) begin fails++; $display("FAIL fill_id1_%0d: got %h expected %h", c, s_id[15:8], e1); end
      tick();
    end
    s_req = 2'b00;
    #1;
    checks++; if (s_count !== 3'd6) begin fails++; $display("FAIL fill_count: got %0d expected 6", s_count); end
    checks++; if (s_full !== 1'b1) begin fails++; $display("FAIL fill_full: got %b expected 1", s_full); end
    checks++; if (s_ready !== 1'b1) begin fails++; $display("FAIL fill_ready_noreq: got %b expected 1", s_ready); end
    s_req = 2'b01;
    #1;
    checks++; if (s_ready !== 1'b0) begin fails++; $display("FAIL fill_ready_full: got %b expected 0", s_ready); end
    tick();
    s_req = 2'b00;
    checks++; if (s_count !== 3'd6) begin fails++; $display("FAIL fill_count_hold: got %0d expected 6", s_count); end
  endtask

  task automatic test_wrap();
    s_free = 2'b11;
    tick(); tick();
    s_free = 2'b00;
    checks++; if (s_head !== 8'h84) begin fails++; $display("FAIL wrap_head_pre: got %h expected 84", s_head); end
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    checks++; if (s_head !== 8'h04) begin fails++; $display("FAIL wrap_flush_head: got %h expected 04", s_head); end
    checks++; if (s_empty !== 1'b1) begin fails++; $display("FAIL wrap_flush_empty: got %b expected 1", s_empty); end
    s_req = 2'b11;
    #1;
    checks++; if (s_id !== 16'h8584) begin fails++; $display("FAIL wrap_ids_a: got %h expected 8584", s_id); end
    tick();
    checks++; if (s_id !== 16'h8180) begin fails++; $display("FAIL wrap_ids_b: got %h expected 8180", s_id); end
    tick();
    s_req = 2'b00;
    checks++; if (s_count !== 3'd4) begin fails++; $display("FAIL wrap_count4: got %0d expected 4", s_count); end
    s_free = 2'b11;
    tick();
    s_free = 2'b01;
    tick();
    s_free = 2'b00;
    checks++; if (s_head !== 8'h81) begin fails++; $display("FAIL wrap_head: got %h expected 81", s_head); end
    checks++; if (s_count !== 3'd1) begin fails++; $display("FAIL wrap_count1: got %0d expected 1", s_count); end
  endtask

  task automatic test_sparse();
    s_req = 2'b01;
    #1;
    checks++; if (s_id[7:0] !== 8'h82) begin fails++; $display("FAIL sparse_pre: got %h expected 82", s_id[7:0]); end
    tick();
    s_req = 2'b10;
    #1;
    checks++; if (s_id[15:8] !== 8'h83) begin fails++; $display("FAIL sparse_lane1: got %h expected 83", s_id[15:8]); end
    checks++; if (s_id[7] !== 1'b0) begin fails++; $display("FAIL sparse_lane0_msb: got %b expected 0", s_id[7]); end
    tick();
    s_req = 2'b00;
    checks++; if (s_count !== 3'd3) begin fails++; $display("FAIL sparse_count: got %0d expected 3", s_count); end
  endtask

  task automatic test_flush_alloc();
    s_flush = 1'b1; s_req = 2'b11;
    #1;
    checks++; if (s_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b expected 0", s_ready); end
    tick();
    s_flush = 1'b0; s_req = 2'b00;
    checks++; if (s_count !== 3'd0) begin fails++; $display("FAIL flush_count: got %0d expected 0", s_count); end
    checks++; if (s_empty !== 1'b1) begin fails++; $display("FAIL flush_empty: got %b expected 1", s_empty); end
    checks++; if (s_err !== 1'b0) begin fails++; $display("FAIL flush_err: got %b expected 0", s_err); end
  endtask

  task automatic test_free_err();
    s_req = 2'b01;
    tick();
    s_req = 2'b00;
    checks++; if (s_count !== 3'd1) begin fails++; $display("FAIL ferr_pre_count: got %0d expected 1", s_count); end
    s_free = 2'b11;
    tick();
    s_free = 2'b00;
    checks++; if (s_count !== 3'd0) begin fails++; $display("FAIL ferr_count: got %0d expected 0", s_count); end
    checks++; if (s_err !== 1'b1) begin fails++; $display("FAIL ferr_err: got %b expected 1", s_err); end
    tick(); tick();
    checks++; if (s_err !== 1'b1) begin fails++; $display("FAIL ferr_sticky: got %b expected 1", s_err); end
  endtask

  task automatic test_async_reset();
    s_req = 2'b11;
    tick();
    #2;
    s_rst = 1'b1;
    #1;
    checks++; if (s_count !== 3'd0) begin fails++; $display("FAIL arst_count: got %0d expected 0", s_count); end
    checks++; if (s_err !== 1'b0) begin fails++; $display("FAIL arst_err: got %b expected 0", s_err); end
    checks++; if (s_head !== 8'h00) begin fails++; $display("FAIL arst_head: got %h expected 00", s_head); end
    checks++; if (s_ready !== 1'b0) begin fails++; $display("FAIL arst_ready: got %b expected 0", s_ready); end
    checks++; if ({s_id[15], s_id[7]} !== 2'b00) begin fails++; $display("FAIL arst_id_msb: got %b expected 00", {s_id[15], s_id[7]}); end
    s_req = 2'b00;
    tick();
    s_rst = 1'b0;
    tick();
  endtask

  task automatic test_rollback();
    build_2_7();
    checks++; if (l_count !== 6'd6) begin fails++; $display("FAIL rb_build_count: got %0d expected 6", l_count); end
    checks++; if (l_head !== 8'h82) begin fails++; $display("FAIL rb_build_head: got %h expected 82", l_head); end
    l_rbv = 1'b1; l_rbid = 7'd4; l_incl = 1'b0;
    tick();
    l_rbv = 1'b0;
    checks++; if (l_count !== 6'd3) begin fails++; $display("FAIL rb_keep_count: got %0d expected 3", l_count); end
    l_req = 2'b01;
    #1;
    checks++; if (l_id[7:0] !== 8'h85) begin fails++; $display("FAIL rb_keep_tail: got %h expected 85", l_id[7:0]); end
    l_req = 2'b11;
    tick();
    l_req = 2'b01;
    tick();
    l_req = 2'b00;
    l_rbv = 1'b1; l_rbid = 7'd4; l_incl = 1'b1; l_free = 2'b01;
    tick();
    l_rbv = 1'b0; l_free = 2'b00;
    checks++; if (l_head !== 8'h83) begin fails++; $display("FAIL rb_incl_head: got %h expected 83", l_head); end
    checks++; if (l_count !== 6'd1) begin fails++; $display("FAIL rb_incl_count: got %0d expected 1", l_count); end
    checks++; if (l_err !== 1'b0) begin fails++; $display("FAIL rb_incl_err: got %b expected 0", l_err); end
    l_req = 2'b01;
    #1;
    checks++; if (l_id[7:0] !== 8'h84) begin fails++; $display("FAIL rb_incl_tail: got %h expected 84", l_id[7:0]); end
    l_req = 2'b00;
    l_rbv = 1'b1; l_rbid = 7'd3; l_incl = 1'b1; l_free = 2'b01;
    tick();
    l_rbv = 1'b0; l_free = 2'b00;
    checks++; if (l_count !== 6'd0) begin fails++; $display("FAIL rb_drain_count: got %0d expected 0", l_count); end
    checks++; if (l_head !== 8'h03) begin fails++; $display("FAIL rb_drain_head: got %h expected 03", l_head); end
    checks++; if (l_err !== 1'b0) begin fails++; $display("FAIL rb_drain_err: got %b expected 0", l_err); end
    l_req = 2'b01;
    #1;
    checks++; if (l_id[7:0] !== 8'h83) begin fails++; $display("FAIL rb_drain_tail: got %h expected 83", l_id[7:0]); end
    l_req = 2'b00;
  endtask

  task automatic test_rb_errors();
    l_rst = 1'b1;
    tick();
    l_rst = 1'b0;
    build_2_7();
    l_rbv = 1'b1; l_rbid = 7'd9; l_incl = 1'b0;
    tick();
    l_rbv = 1'b0;
    checks++; if (l_count !== 6'd6) begin fails++; $display("FAIL rberr_count: got %0d expected 6", l_count); end
    checks++; if (l_head !== 8'h82) begin fails++; $display("FAIL rberr_head: got %h expected 82", l_head); end
    checks++; if (l_err !== 1'b1) begin fails++; $display("FAIL rberr_err: got %b expected 1", l_err); end
    l_req = 2'b01;
    #1;
    checks++; if (l_id[7:0] !== 8'h88) begin fails++; $display("FAIL rberr_tail: got %h expected 88", l_id[7:0]); end
    l_req = 2'b00;
    l_rbv = 1'b1; l_rbid = 7'd40; l_incl = 1'b1;
    tick();
    l_rbv = 1'b0;
    checks++; if (l_count !== 6'd6) begin fails++; $display("FAIL rberr_range_count: got %0d expected 6", l_count); end
    tick();
    checks++; if (l_err !== 1'b1) begin fails++; $display("FAIL rberr_sticky: got %b expected 1", l_err); end
  endtask

  initial begin
    s_req = '0; s_free = '0; s_rbv = 0; s_rbid = '0; s_incl = 0; s_flush = 0; s_rst = 1;
    l_req = '0; l_free = '0; l_rbv = 0; l_rbid = '0; l_incl = 0; l_flush = 0; l_rst = 1;
    test_reset();
    test_fill();
    test_wrap();
    test_sparse();
    test_flush_alloc();
    test_free_err();
    test_async_reset();
    test_rollback();
    test_rb_errors();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/id_alloc_queue.md
# id_alloc_queue

Parametrised in-order ID allocator for the out-of-order core. It hands out branch, load or store IDs (brid/ldid/stid) in the codebase's MSB-valid ID format to up to ALLOC decode lanes per cycle. IDs are released in program order at commit, up to FREE per cycle. On redirect it rolls the allocation tail back to a given ID, or it flushes everything. One instance is used per ID class; it sits between decode (allocation) and commit/redirect (release and rollback).

## Interface
- WIDTH, 7: ID bits excluding the valid bit. ID fields are WIDTH+1 bits with the MSB as the valid bit.
- DEPTH, 32: number of IDs, 2..2^WIDTH. Need not be a power of two.
- ALLOC, 2: allocation lanes, 1..8.
- FREE, 2: release lanes, 1..8.
- CW, $clog2(DEPTH+1): width of the count output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_req  in  ALLOC  per-lane allocation request; any bit pattern is allowed.
- alloc_ready  out  1  high when popcount(alloc_req) <= free slots and there is no rb_valid/flush and no rst.
- alloc_id  out  ALLOC×(WIDTH+1)  granted ID per lane; MSB set only for lanes where alloc_req & alloc_ready.
- free_en  in  FREE  release requests; popcount(free_en) oldest IDs are released.
- rb_valid  in  1  rollback request.
- rb_id  in  WIDTH  rollback anchor ID.
- rb_incl  in  1  1 = discard rb_id as well; 0 = keep rb_id.
- flush  in  1  discard all live IDs.
- head_id  out  WIDTH+1  oldest live ID; MSB = !empty.
- count  out  CW  number of live IDs.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- err  out  1  sticky protocol-error flag, cleared only by rst.

## Operation
- State: head pointer, tail pointer (each 0..DEPTH-1, incrementing with wrap DEPTH-1 -> 0), and count (0..DEPTH). No per-entry storage.
- Allocation is all-or-nothing:
  - If alloc_ready, requesting lanes in ascending lane order receive tail, tail+1, … (mod DEPTH).
  - tail advances by n = popcount(alloc_req); count += n.
  - Non-requesting lanes get MSB 0; their low bits are don't-care.
- Release: f = popcount(free_en). head += f (mod DEPTH), count -= f.
  - If f > count (using count before any same-cycle allocation), release is clamped to count and err is set.
- Rollback (rb_valid):
  - d = (rb_id - head) mod DEPTH.
  - If d >= count, or rb_id >= DEPTH: ignore the rollback and set err.
  - Otherwise the new tail is rb_id+1 (rb_incl=0) or rb_id (rb_incl=1), mod DEPTH, and count = d + !rb_incl.
  - Releases in the same cycle still apply to head. The new count is (d + !rb_incl) - f. If this would go negative (rb_incl=1 and f > d), head = tail and count = 0, with no err.
- flush: tail = head after applying same-cycle releases; count = 0. flush overrides rb_valid.
- Priority within a cycle: rst > flush > rb_valid > alloc. Release always applies (subject to clamping).

## Timing
- alloc_id, alloc_ready, head_id, empty, full, and count are combinational from current state, except alloc_ready also depends on alloc_req, rb_valid, and flush. An allocated ID is live from the next edge.
- alloc_ready does not account for same-cycle releases. Freed slots become usable the cycle after.
- Rollback, flush and release take effect at the next edge. The cycle after a rollback, alloc_id reflects the new tail.
- Reset values, held while rst is high: head = tail = 0, count = 0, empty = 1, full = 0, head_id = 0, err = 0, alloc_ready = 0, all alloc_id MSBs = 0. Reset asserted mid-operation discards all state immediately.
- Wrap-around: IDs after DEPTH-1 continue at 0 with no gap.
- full: alloc_ready is 0 whenever any request is present. It stays 1 when alloc_req = 0.

## Test plan
- Reset then fill (DEPTH=6, ALLOC=2): alloc_req=2'b11 for 3 cycles gives IDs {0,1}, {2,3}, {4,5}, all with MSB=1. Next cycle count=6, full=1, and alloc_ready=0 with req=2'b01.
- Sparse lanes: alloc_req=2'b10 at tail=3 -> lane1 gets 0x83, lane0 MSB=0; count+1.
- Wrap: DEPTH=6, head=4, tail=4, count=0. Allocate 2×2 -> IDs 4,5,0,1. Free 3 -> head_id=0x81, count=1.
- Rollback: live IDs 2..7 (DEPTH=32). rb_id=4 with rb_incl=0 -> tail=5, count=3. Repeat with rb_incl=1 and free_en=2'b01 in the same cycle -> head=3, tail=4, count=1, no err.
- Errors: rb_id=9 while live IDs are 2..7 -> state unchanged and err=1. Separately, free_en=2'b11 with count=1 -> count=0, err=1. err stays high until rst.
- Flush while allocating: flush=1 together with alloc_req=2'b11 -> alloc_ready=0, then count=0 and empty=1. Asserting rst asynchronously mid-cycle clears all outputs immediately.
